// File: rtl/nn_cost_sequencer.sv
// nn_cost_sequencer: steps the stochastic cross-entropy cost block through a
// training batch. For each sample it requests the sample, pulses a clear,
// discards a settling interval, then integrates the signed cost bitstream.
module nn_cost_sequencer #(
  parameter int unsigned WINDOW_LEN = 256,
  parameter int unsigned SETTLE_LEN = 8,
  parameter int unsigned N_SAMPLES  = 16,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned IDX_W      = 4
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             START,
  input  logic             ABORT,
  input  logic             SAMPLE_ACK,
  input  logic             COST_BIT,
  input  logic             COST_SIGN,
  output logic             SAMPLE_REQ,
  output logic [IDX_W-1:0] SAMPLE_IDX,
  output logic             COST_INIT,
  output logic             R_COND,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic             ERR_VALID,
  output logic             BUSY,
  output logic             DONE
);

  // One shared interval timer serves both the settle and the window phases.
  localparam int unsigned TMR_MAX = (WINDOW_LEN > SETTLE_LEN) ? WINDOW_LEN : SETTLE_LEN;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_LEN - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_ACCUM,
    ST_REPORT,
    ST_FINISH
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_c;

  // Signed step of the running sum for the current cost bit.
  always_comb begin
    acc_c = acc;
    if (COST_BIT) begin
      acc_c = COST_SIGN ? (acc - CNT_W'(1)) : (acc + CNT_W'(1));
    end
  end

  // Sequencer state, timer, accumulator and all registered outputs.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      acc        <= '0;
      SAMPLE_REQ <= 1'b0;
      SAMPLE_IDX <= '0;
      COST_INIT  <= 1'b0;
      R_COND     <= 1'b0;
      ERR_COUNT  <= '0;
      ERR_VALID  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else if (ABORT && (state != ST_IDLE)) begin
      // Abort drops the batch silently; ERR_COUNT keeps the last report.
      state      <= ST_IDLE;
      tmr        <= '0;
      SAMPLE_REQ <= 1'b0;
      COST_INIT  <= 1'b0;
      R_COND     <= 1'b0;
      ERR_VALID  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      COST_INIT <= 1'b0;
      ERR_VALID <= 1'b0;
      DONE      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state      <= ST_LOAD;
            SAMPLE_IDX <= '0;
            acc        <= '0;
            SAMPLE_REQ <= 1'b1;
            BUSY       <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (SAMPLE_ACK) begin
            state      <= ST_CLEAR;
            SAMPLE_REQ <= 1'b0;
            COST_INIT  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state  <= ST_SETTLE;
          tmr    <= '0;
          R_COND <= 1'b0;
        end
        ST_SETTLE: begin
          R_COND <= ~R_COND;
          if (tmr == SETTLE_LAST) begin
            state <= ST_ACCUM;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_ACCUM: begin
          if (tmr == WINDOW_LAST) begin
            state     <= ST_REPORT;
            tmr       <= '0;
            R_COND    <= 1'b0;
            ERR_COUNT <= acc_c;
            ERR_VALID <= 1'b1;
            acc       <= '0;
          end else begin
            R_COND <= ~R_COND;
            tmr    <= tmr + TMR_W'(1);
            acc    <= acc_c;
          end
        end
        ST_REPORT: begin
          if (SAMPLE_IDX == IDX_LAST) begin
            state <= ST_FINISH;
            DONE  <= 1'b1;
          end else begin
            state      <= ST_LOAD;
            SAMPLE_IDX <= SAMPLE_IDX + IDX_W'(1);
            SAMPLE_REQ <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_cost_sequencer.sv
// tb_nn_cost_sequencer: directed batch scenarios with randomized cost streams
// and ACK delays, checked against a per-sample window-sum model.
module tb_nn_cost_sequencer;

  localparam int unsigned WL = 8;
  localparam int unsigned SL = 2;
  localparam int unsigned NS = 3;
  localparam int unsigned CW = 10;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = SL + WL;

  logic          CLK = 1'b0;
  logic          INIT, START, ABORT, SAMPLE_ACK, COST_BIT, COST_SIGN;
  logic          SAMPLE_REQ, COST_INIT, R_COND, ERR_VALID, BUSY, DONE;
  logic [IW-1:0] SAMPLE_IDX;
  logic [CW-1:0] ERR_COUNT;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  logic [CW-1:0] last_err = '0;

  nn_cost_sequencer #(
    .WINDOW_LEN(WL), .SETTLE_LEN(SL), .N_SAMPLES(NS), .CNT_W(CW), .IDX_W(IW)
  ) dut (
    .CLK(CLK), .INIT(INIT), .START(START), .ABORT(ABORT),
    .SAMPLE_ACK(SAMPLE_ACK), .COST_BIT(COST_BIT), .COST_SIGN(COST_SIGN),
    .SAMPLE_REQ(SAMPLE_REQ), .SAMPLE_IDX(SAMPLE_IDX), .COST_INIT(COST_INIT),
    .R_COND(R_COND), .ERR_COUNT(ERR_COUNT), .ERR_VALID(ERR_VALID),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},  32'(SAMPLE_REQ), 0);
    check({tag, ".idx"},  32'(SAMPLE_IDX), 0);
    check({tag, ".cini"}, 32'(COST_INIT),  0);
    check({tag, ".rc"},   32'(R_COND),     0);
    check({tag, ".cnt"},  32'(ERR_COUNT),  0);
    check({tag, ".ev"},   32'(ERR_VALID),  0);
    check({tag, ".busy"}, 32'(BUSY),       0);
    check({tag, ".done"}, 32'(DONE),       0);
  endtask

  // One sample from its first LOAD cycle to its REPORT cycle.
  // pat: 0 random, 1 all +1, 2 five negatives/three positives.
  // mode: 0 normal, 1 ABORT at window cycle kill_at, 2 INIT at window cycle kill_at.
  task automatic do_sample(input int idx, input int ack_wait, input int pat,
                           input int mode, input int kill_at,
                           input bit start_glitch, input bit check_lat);
    bit            cb [SW];
    bit            cs [SW];
    int            sum;
    logic [CW-1:0] exp_cnt;
    sum = 0;
    for (int j = 0; j < int'(SW); j++) begin
      cb[j] = 1'($urandom);
      cs[j] = 1'($urandom);
      if (j >= int'(SL)) begin
        if (pat == 1) begin
          cb[j] = 1'b1; cs[j] = 1'b0;
        end else if (pat == 2) begin
          cb[j] = 1'b1;
          cs[j] = ((j - int'(SL)) < 7) ? (((j - int'(SL)) % 2) == 0) : 1'b1;
        end
        if (cb[j]) sum += cs[j] ? -1 : 1;
      end
    end
    exp_cnt = CW'(sum);

    check($sformatf("s%0d.load.req", idx),  32'(SAMPLE_REQ), 1);
    check($sformatf("s%0d.load.idx", idx),  32'(SAMPLE_IDX), 32'(idx));
    check($sformatf("s%0d.load.busy", idx), 32'(BUSY),       1);
    if (start_glitch) START = 1'b1;
    for (int i = 0; i < ack_wait; i++) begin
      SAMPLE_ACK = 1'b0;
      tick();
      check($sformatf("s%0d.wait.req", idx),  32'(SAMPLE_REQ), 1);
      check($sformatf("s%0d.wait.cini", idx), 32'(COST_INIT),  0);
    end
    SAMPLE_ACK = 1'b1;
    tick();
    SAMPLE_ACK = 1'b0;
    check($sformatf("s%0d.clr.cini", idx), 32'(COST_INIT),  1);
    check($sformatf("s%0d.clr.req", idx),  32'(SAMPLE_REQ), 0);
    check($sformatf("s%0d.clr.rc", idx),   32'(R_COND),     0);

    for (int j = 0; j < int'(SW); j++) begin
      tick();
      check($sformatf("s%0d.c%0d.rc", idx, j),   32'(R_COND),    32'(j % 2));
      check($sformatf("s%0d.c%0d.cini", idx, j), 32'(COST_INIT), 0);
      check($sformatf("s%0d.c%0d.ev", idx, j),   32'(ERR_VALID), 0);
      if (mode == 1 && j == int'(SL) + kill_at) begin
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        START = 1'b0;
        check("abort.busy", 32'(BUSY),       0);
        check("abort.req",  32'(SAMPLE_REQ), 0);
        check("abort.ev",   32'(ERR_VALID),  0);
        check("abort.done", 32'(DONE),       0);
        check("abort.cnt",  32'(ERR_COUNT),  32'(last_err));
        tick();
        check("abort.idle.busy", 32'(BUSY), 0);
        check("abort.idle.ev",   32'(ERR_VALID), 0);
        check("abort.idle.done", 32'(DONE), 0);
        return;
      end
      if (mode == 2 && j == int'(SL) + kill_at) begin
        #1;
        INIT  = 1'b1;
        START = 1'b1;
        #1;
        check_all_zero("init.async");
        tick();
        tick();
        check("init.held.busy", 32'(BUSY),       0);
        check("init.held.req",  32'(SAMPLE_REQ), 0);
        INIT  = 1'b0;
        START = 1'b0;
        tick();
        check_all_zero("init.release");
        last_err = '0;
        return;
      end
      COST_BIT  = cb[j];
      COST_SIGN = cs[j];
    end

    tick();
    COST_BIT  = 1'b0;
    COST_SIGN = 1'b0;
    START     = 1'b0;
    check($sformatf("s%0d.rep.ev", idx),   32'(ERR_VALID),  1);
    check($sformatf("s%0d.rep.cnt", idx),  32'(ERR_COUNT),  32'(exp_cnt));
    check($sformatf("s%0d.rep.idx", idx),  32'(SAMPLE_IDX), 32'(idx));
    check($sformatf("s%0d.rep.rc", idx),   32'(R_COND),     0);
    check($sformatf("s%0d.rep.done", idx), 32'(DONE),       0);
    if (check_lat) check("latency", 32'(cyc), 13);
    last_err = exp_cnt;
  endtask

  // After the last REPORT: one DONE, then BUSY drops and the FSM idles.
  task automatic check_finish();
    tick();
    check("fin.done", 32'(DONE),      1);
    check("fin.ev",   32'(ERR_VALID), 0);
    check("fin.busy", 32'(BUSY),      1);
    tick();
    check("idle.done", 32'(DONE),       0);
    check("idle.busy", 32'(BUSY),       0);
    check("idle.idx",  32'(SAMPLE_IDX), NS - 1);
    check("idle.cnt",  32'(ERR_COUNT),  32'(last_err));
    tick();
    check("idle2.busy", 32'(BUSY),       0);
    check("idle2.req",  32'(SAMPLE_REQ), 0);
    check("idle2.done", 32'(DONE),       0);
  endtask

  initial begin
    INIT = 1'b1; START = 1'b1; ABORT = 1'b0; SAMPLE_ACK = 1'b0;
    COST_BIT = 1'b0; COST_SIGN = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    INIT  = 1'b0;
    START = 1'b0;
    tick();
    check("post_reset.busy", 32'(BUSY), 0);

    // Batch A: all +1, signed mix with slow ACK and stray START, random.
    START = 1'b1;
    tick();
    cyc   = 1;
    START = 1'b0;
    do_sample(0, 0, 1, 0, 0, 0, 1);
    tick();
    do_sample(1, 5, 2, 0, 0, 1, 0);
    tick();
    do_sample(2, int'($urandom_range(3, 0)), 0, 0, 0, 0, 0);
    check_finish();

    // Batch B: START beats ABORT in IDLE, then abort sample 1 mid-window.
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    do_sample(0, int'($urandom_range(3, 0)), 0, 0, 0, 0, 0);
    tick();
    do_sample(1, int'($urandom_range(3, 0)), 0, 1, int'($urandom_range(WL - 1, 0)), 0, 0);

    // Restart after abort begins again at sample 0.
    START = 1'b1;
    tick();
    START = 1'b0;
    do_sample(0, int'($urandom_range(4, 0)), 0, 0, 0, 0, 0);
    tick();
    do_sample(1, int'($urandom_range(4, 0)), 0, 0, 0, 1, 0);
    tick();
    do_sample(2, int'($urandom_range(4, 0)), 0, 0, 0, 0, 0);
    check_finish();

    // Batch C: asynchronous INIT in the middle of the window.
    START = 1'b1;
    tick();
    START = 1'b0;
    do_sample(0, 1, 0, 2, int'($urandom_range(WL - 1, 0)), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
